// File: rtl/lms_pkg.sv
// lms_pkg: shared types and helpers for the LMS coefficient adaptation engine.
//   lms_state_t   - controller state encoding (IDLE, UPDATE, COMMIT)
//   sat_to_width  - clamps a signed 64-bit value to the range of a w-bit
//                   signed word; the result stays 64 bits wide so callers
//                   cast it down to the width they need.
package lms_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } lms_state_t;

    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        else
            return v;
    endfunction

endpackage

// File: rtl/lms_tap_update.sv
// lms_tap_update: combinational single-tap LMS update.
//   coeff_new = sat(coeff + sat((err * x) >>> (FRAC + MU_SHIFT)))
// With LMS_LEAKAGE_EN defined the coefficient also leaks toward zero:
//   coeff_new = sat(coeff - (coeff >>> LEAK_SHIFT) + d)
// Ports:
//   coeff     in   current coefficient
//   err       in   latched error sample
//   x         in   history sample weighted by this coefficient
//   coeff_new out  updated coefficient
import lms_pkg::*;

module lms_tap_update #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 8
) (
    input  logic signed [WIDTH-1:0] coeff,
    input  logic signed [WIDTH-1:0] err,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] coeff_new
);

    logic signed [63:0] d_full;
    logic signed [63:0] d_sat;
    logic signed [63:0] sum;

    // Operands are widened before the multiply so the full product is kept;
    // the arithmetic shift floors toward minus infinity.
    assign d_full = (64'(err) * 64'(x)) >>> (FRAC + MU_SHIFT);
    assign d_sat  = sat_to_width(d_full, WIDTH);

`ifdef LMS_LEAKAGE_EN
    assign sum = 64'(coeff) - 64'(coeff >>> LEAK_SHIFT) + d_sat;
`else
    logic unused_leak;
    assign unused_leak = ^LEAK_SHIFT;
    assign sum = 64'(coeff) + d_sat;
`endif

    assign coeff_new = WIDTH'(sat_to_width(sum, WIDTH));

endmodule

// File: rtl/lms_coeff_update.sv
// lms_coeff_update: sample-serial LMS coefficient adaptation engine.
// One beat (din, err) updates every coefficient, one tap per cycle through a
// single shared lms_tap_update, into a shadow copy; the whole vector is then
// published on one edge so the FIR never sees a partially updated set.
// Optional feature: define LMS_LEAKAGE_EN for leaky LMS (see lms_tap_update).
// Ports:
//   clk           in   clock
//   rstn          in   asynchronous active-low reset
//   in_valid      in   beat present on din/err
//   in_ready      out  high only in IDLE
//   din           in   new input sample x[n+1]
//   err           in   error for the current history vector
//   coeffs        out  published coefficients, coeffs[k] weights x[n-k]
//   coeffs_valid  out  one-cycle pulse on the edge coeffs is updated
//
// state  | meaning
// IDLE   | waiting for a beat; in_ready high
// UPDATE | updating shadow[k], one tap per cycle, k = 0 .. TAPS-1
// COMMIT | publish shadow to coeffs, shift din_q into the history
import lms_pkg::*;

module lms_coeff_update #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 14,
    parameter int TAPS       = 8,
    parameter int MU_SHIFT   = 4,
    parameter int LEAK_SHIFT = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            din,
    input  logic [WIDTH-1:0]            err,
    output logic [TAPS-1:0][WIDTH-1:0]  coeffs,
    output logic                        coeffs_valid
);

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

    lms_state_t                state;
    logic [KW-1:0]             k;
    logic [WIDTH-1:0]          err_q;
    logic [WIDTH-1:0]          din_q;
    logic [TAPS-1:0][WIDTH-1:0] hist;
    logic [TAPS-1:0][WIDTH-1:0] shadow;
    logic [WIDTH-1:0]          tap_new;

    assign in_ready = (state == IDLE);

    lms_tap_update #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .MU_SHIFT   (MU_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_tap (
        .coeff     (shadow[k]),
        .err       (err_q),
        .x         (hist[k]),
        .coeff_new (tap_new)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            k            <= '0;
            err_q        <= '0;
            din_q        <= '0;
            hist         <= '0;
            shadow       <= '0;
            coeffs       <= '0;
            coeffs_valid <= 1'b0;
        end else begin
            coeffs_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        err_q  <= err;
                        din_q  <= din;
                        k      <= '0;
                        shadow <= coeffs;
                        state  <= UPDATE;
                    end
                end
                UPDATE: begin
                    shadow[k] <= tap_new;
                    if (k == KW'(TAPS - 1))
                        state <= COMMIT;
                    else
                        k <= k + KW'(1);
                end
                COMMIT: begin
                    coeffs       <= shadow;
                    coeffs_valid <= 1'b1;
                    // History moves only after the update so err stays aligned
                    // with the vector it was measured against.
                    hist         <= {hist[TAPS-2:0], din_q};
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
